// File: rtl/riscv_mult_arb_pkg.sv
// Shared types for the multiplier arbiter: controller states and the latched
// request bundle that feeds the multiplier's operand inputs.
package riscv_mult_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  short_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } mult_req_t;

endpackage

// File: rtl/riscv_rr_arb.sv
// Round-robin priority pick: grants the lowest-index requester at or after
// i_ptr, wrapping around, as a one-hot vector plus its binary index.
module riscv_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  logic        w_found;
  int unsigned w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/riscv_mult_arb.sv
// Round-robin controller sharing one sequential multiplier between NUM_REQ
// requesters: latch operands, sequence enable/ready, return a registered result.
module riscv_mult_arb
  import riscv_mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*3-1:0]   req_operator_i,
  input  logic [NUM_REQ*2-1:0]   req_short_signed_i,
  input  logic [NUM_REQ*32-1:0]  req_op_a_i,
  input  logic [NUM_REQ*32-1:0]  req_op_b_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic [31:0]            rsp_result_o,
  output logic                   busy_o,
  output logic                   mult_enable_o,
  output logic [2:0]             mult_operator_o,
  output logic [1:0]             mult_short_signed_o,
  output logic [31:0]            mult_op_a_o,
  output logic [31:0]            mult_op_b_o,
  input  logic [31:0]            mult_result_i,
  input  logic                   mult_ready_i
);

  state_e             r_state;
  mult_req_t          r_req;
  logic [IDW-1:0]     r_owner;
  logic [IDW-1:0]     r_rr_ptr;
  logic [31:0]        r_result;
  logic               r_mult_en;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grant_idx;
  logic [IDW-1:0]     w_next_ptr;
  logic               w_take;
  mult_req_t          w_sel;

  riscv_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  assign w_take      = (r_state == S_IDLE) && !flush_i && (|req_valid_i);
  assign req_ready_o = w_take ? w_grant : '0;
  assign w_next_ptr  = (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.op           = req_operator_i[i*3 +: 3];
        w_sel.short_signed = req_short_signed_i[i*2 +: 2];
        w_sel.op_a         = req_op_a_i[i*32 +: 32];
        w_sel.op_b         = req_op_b_i[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_result    <= '0;
      r_mult_en   <= 1'b0;
      r_rsp_valid <= '0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      r_mult_en   <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_req     <= w_sel;
            r_owner   <= w_grant_idx;
            r_rr_ptr  <= w_next_ptr;
            r_mult_en <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (mult_ready_i) begin
            r_result    <= mult_result_i;
            r_mult_en   <= 1'b0;
            r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_mult_en   <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Flush masks the response in its own cycle so a coincident rsp_ready_i
  // cannot complete a handshake on a result that is being dropped.
  assign rsp_valid_o         = flush_i ? '0 : r_rsp_valid;
  assign rsp_result_o        = r_result;
  assign busy_o              = (r_state != S_IDLE);
  assign mult_enable_o       = r_mult_en;
  assign mult_operator_o     = r_req.op;
  assign mult_short_signed_o = r_req.short_signed;
  assign mult_op_a_o         = r_req.op_a;
  assign mult_op_b_o         = r_req.op_b;

endmodule

// File: tb/tb_riscv_mult_arb.sv
// Scoreboard bench for riscv_mult_arb with a 3-cycle behavioural multiplier.
module tb_riscv_mult_arb;

  localparam int NR = 2;
  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_H     = 3'b110;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic [NR-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NR*3-1:0]  req_operator_i;
  logic [NR*2-1:0]  req_short_signed_i;
  logic [NR*32-1:0] req_op_a_i, req_op_b_i;
  logic [31:0]      rsp_result_o, mult_op_a_o, mult_op_b_o, mult_result_i;
  logic             busy_o, mult_enable_o, mult_ready_i;
  logic [2:0]       mult_operator_o;
  logic [1:0]       mult_short_signed_o;

  riscv_mult_arb #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_short_signed_i(req_short_signed_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .busy_o(busy_o), .mult_enable_o(mult_enable_o),
    .mult_operator_o(mult_operator_o), .mult_short_signed_o(mult_short_signed_o),
    .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o),
    .mult_result_i(mult_result_i), .mult_ready_i(mult_ready_i)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done three cycles after the enable rising edge.
  int unsigned mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 0;
    else if (!mult_enable_o) mcnt <= 0;
    else if (mcnt < 7) mcnt <= mcnt + 1;
  end

  function automatic logic [31:0] mul_model(input logic [2:0] op, input logic [1:0] ss,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ae, be;
    logic signed [65:0] p;
    ae = {ss[0] & a[31], a};
    be = {ss[1] & b[31], b};
    p  = 66'(ae) * 66'(be);
    if (op == MUL_H) return p[63:32];
    return a * b;
  endfunction

  assign mult_ready_i  = mult_enable_o && (mcnt == 3);
  assign mult_result_i = mult_ready_i ?
      mul_model(mult_operator_o, mult_short_signed_o, mult_op_a_o, mult_op_b_o) : 32'hDEADBEEF;

  typedef struct { int idx; logic [31:0] res; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && |(rsp_valid_o & rsp_ready_i)) begin
      if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", 64'(rsp_valid_o), 64'(1 << e.idx));
        chk("rsp_result", 64'(rsp_result_o), 64'(e.res));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [1:0] ss,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid_i[idx]              = 1'b1;
    req_operator_i[idx*3 +: 3]    = op;
    req_short_signed_i[idx*2 +: 2] = ss;
    req_op_a_i[idx*32 +: 32]      = a;
    req_op_b_i[idx*32 +: 32]      = b;
  endtask

  task automatic wait_grant();
    @(negedge clk);
    for (int n = 0; n < 20 && req_ready_o == '0; n++) @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Lone request with full cycle-exact timing checks from grant T to T+6.
  task automatic run_op(input int idx, input logic [2:0] op, input logic [1:0] ss,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    step();
    set_req(idx, op, ss, a, b);
    e.idx = idx; e.res = exp;
    sb.push_back(e);
    @(negedge clk);
    chk("grant_T", 64'(req_ready_o), 64'(1 << idx));
    chk("en_T", 64'(mult_enable_o), 64'd0);
    step();
    req_valid_i = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("en_T1_T4", 64'(mult_enable_o), 64'd1);
      chk("no_grant_busy", 64'(req_ready_o), 64'd0);
      if (c == 2) begin
        chk("mult_op_a", 64'(mult_op_a_o), 64'(a));
        chk("mult_op_b", 64'(mult_op_b_o), 64'(b));
      end
      step();
    end
    @(negedge clk);
    chk("rsp_T5", 64'(rsp_valid_o), 64'(1 << idx));
    chk("en_T5", 64'(mult_enable_o), 64'd0);
    step();
    @(negedge clk);
    chk("idle_T6", 64'(busy_o), 64'd0);
  endtask

  int alt_a[4] = '{2, 10, 4, 12};
  int alt_b[4] = '{3, 11, 5, 13};
  int alt_r[4] = '{6, 110, 20, 156};

  initial begin
    exp_t e;
    int   ix;
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = '0; rsp_ready_i = '1;
    req_operator_i = '0; req_short_signed_i = '0; req_op_a_i = '0; req_op_b_i = '0;
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_en", 64'(mult_enable_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_result", 64'(rsp_result_o), 64'd0);
    chk("rst_op_a", 64'(mult_op_a_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    step();
    rst_n = 1'b1;

    run_op(0, MUL_MAC32, 2'b00, 32'd7, 32'd6, 32'd42);
    run_op(1, MUL_H, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(1, MUL_H, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    drain();

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    set_req(0, MUL_MAC32, 2'b00, 32'(alt_a[0]), 32'(alt_b[0]));
    set_req(1, MUL_MAC32, 2'b00, 32'(alt_a[1]), 32'(alt_b[1]));
    for (int k = 0; k < 4; k++) begin
      ix = k % 2;
      wait_grant();
      chk("alt_grant", 64'(req_ready_o), 64'(1 << ix));
      e.idx = ix; e.res = 32'(alt_r[k]);
      sb.push_back(e);
      step();
      if (k + 2 < 4) set_req(ix, MUL_MAC32, 2'b00, 32'(alt_a[k+2]), 32'(alt_b[k+2]));
      else req_valid_i[ix] = 1'b0;
    end
    drain();

    // Response backpressure with a competing request pending.
    step();
    rsp_ready_i = '0;
    set_req(0, MUL_MAC32, 2'b00, 32'd100, 32'd3);
    e.idx = 0; e.res = 32'd300; sb.push_back(e);
    @(negedge clk);
    chk("bp_grant0", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i[0] = 1'b0;
    set_req(1, MUL_MAC32, 2'b00, 32'd9, 32'd9);
    e.idx = 1; e.res = 32'd81; sb.push_back(e);
    for (int n = 0; n < 20 && rsp_valid_o == '0; n++) @(negedge clk);
    chk("bp_valid_seen", 64'(rsp_valid_o), 64'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_result", 64'(rsp_result_o), 64'd300);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
      chk("bp_en", 64'(mult_enable_o), 64'd0);
    end
    step();
    rsp_ready_i = '1;
    wait_grant();
    chk("bp_grant1", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = '0;
    drain();

    // Flush during WAIT drops the operation; the next request still works.
    step();
    set_req(0, MUL_MAC32, 2'b00, 32'd1000, 32'd1000);
    @(negedge clk);
    chk("fl_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = '0;
    step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_rsp_low", 64'(rsp_valid_o), 64'd0);
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_idle", 64'(busy_o), 64'd0);
    chk("fl_en_low", 64'(mult_enable_o), 64'd0);
    repeat (8) begin
      @(negedge clk);
      chk("fl_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
    run_op(0, MUL_MAC32, 2'b00, 32'd3, 32'd5, 32'd15);
    drain();

    // Asynchronous reset during WAIT, then requester 0 wins first.
    step();
    set_req(1, MUL_MAC32, 2'b00, 32'd7, 32'd7);
    @(negedge clk);
    chk("rs_grant", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = '0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_en", 64'(mult_enable_o), 64'd0);
    chk("rs_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rs_result", 64'(rsp_result_o), 64'd0);
    chk("rs_op_a", 64'(mult_op_a_o), 64'd0);
    chk("rs_op_b", 64'(mult_op_b_o), 64'd0);
    step();
    rst_n = 1'b1;
    set_req(0, MUL_MAC32, 2'b00, 32'd6, 32'd7);
    set_req(1, MUL_MAC32, 2'b00, 32'd8, 32'd8);
    e.idx = 0; e.res = 32'd42; sb.push_back(e);
    @(negedge clk);
    chk("rs_first_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i[0] = 1'b0;
    e.idx = 1; e.res = 32'd64; sb.push_back(e);
    wait_grant();
    chk("rs_second_grant", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/riscv_mult_arb.md
# riscv_mult_arb

Round-robin controller that shares the single sequential 33x33 integer multiplier between NUM_REQ requesters (core EX stage, NPU scalar helper, etc.). It latches one request's operands, sequences the multiplier's edge-triggered start and multi-cycle completion, and returns a registered 32-bit result to the owning requester over a valid/ready handshake. It sits between the requesters and the multiplier and is the only driver of the multiplier's inputs.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- IDW, $clog2(NUM_REQ) (min 1): requester index width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- flush_i  in  1  abort current operation; drop any pending response.
- req_valid_i  in  NUM_REQ  request valid per requester.
- req_ready_o  out  NUM_REQ  one-hot grant; request accepted when valid&ready.
- req_operator_i  in  NUM_REQ x 3  MUL_MAC32 / MUL_H encoding.
- req_short_signed_i  in  NUM_REQ x 2  00 mulhu, 01 mulhsu, 11 mulh.
- req_op_a_i, req_op_b_i  in  NUM_REQ x 32  operands.
- rsp_valid_o  out  NUM_REQ  one-hot result valid to owner.
- rsp_ready_i  in  NUM_REQ  per-requester result accept.
- rsp_result_o  out  32  result, shared bus, valid with rsp_valid_o.
- busy_o  out  1  high in any state but IDLE.
- mult_enable_o  out  1  multiplier enable; start = rising edge.
- mult_operator_o, mult_short_signed_o, mult_op_a_o, mult_op_b_o  out  3/2/32/32  held operands.
- mult_result_i  in  32  multiplier result.
- mult_ready_i  in  1  multiplier done (complete and not start).

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid_i, grant lowest index at/after rr_ptr (round-robin); req_ready_o one-hot same cycle (combinational from valid and ptr); latch operator, short_signed, op_a, op_b, owner id; rr_ptr <= owner+1 (wraps to 0 after NUM_REQ-1); -> ISSUE. No valid: stay, req_ready_o = 0.
- ISSUE: mult_enable_o = 1 (one cycle, rising edge starts multiplier); mult_ready_i ignored; -> WAIT.
- WAIT: mult_enable_o = 1, operands held; on mult_ready_i capture mult_result_i into result register, -> RESP.
- RESP: mult_enable_o = 0; rsp_valid_o[owner] = 1, result stable; on rsp_ready_i[owner] -> IDLE. rsp_ready_i of other bits ignored.
- mult_enable_o low in RESP and IDLE guarantees >=2 low cycles between ops, so every ISSUE is a fresh rising edge.
- mult_* operand outputs driven from latched registers in all states (stable through the multiplier's unregistered-input window and result mux).
- flush_i (any state): next state IDLE, enable low, rsp_valid_o low, result discarded; no grant in the flush cycle; rr_ptr unchanged by flush.
- No request is accepted while busy_o = 1.

## Timing
- Reset values: req_ready_o 0, rsp_valid_o 0, rsp_result_o 0, busy_o 0, mult_enable_o 0, operand outputs 0, rr_ptr 0, state IDLE.
- Grant cycle T; mult_enable_o rises T+1; with multiplier num_cyc=3, mult_ready_i at T+4; rsp_valid_o T+5; earliest next grant T+6 if rsp_ready_i at T+5. Throughput one op per 6 cycles at zero response backpressure.
- mult_ready_i asserted in ISSUE: ignored. Asserted in IDLE/RESP: ignored.
- Simultaneous flush_i and mult_ready_i or rsp_ready_i: flush wins, no response issued.
- Reset mid-operation: immediate return to reset values; multiplier restarts cleanly since enable drops.

## Structure
- Package riscv_mult_arb_pkg: state enum, request struct (operator, short_signed, op_a, op_b). Operator codes stay in decode_param.v.
- Sub-module riscv_rr_arb: parameterised NUM_REQ round-robin priority pick (req vector, ptr -> one-hot grant, index).

## Test plan
- Single request req0 MUL_MAC32 a=7 b=6 -> rsp_valid_o=01 at T+5, result 42; mult_enable_o high exactly T+1..T+4.
- req1 MUL_H short_signed=00 a=b=0xFFFFFFFF -> result 0xFFFFFFFE; short_signed=11 same operands -> 0x00000000.
- Both valid continuously from reset -> grants alternate 0,1,0,1; four results match operands in order.
- Backpressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and result stable, req_ready_o 0, mult_enable_o 0 throughout.
- flush_i in WAIT -> IDLE next cycle, no rsp_valid_o; following request a=3 b=5 returns 15 correctly.
- rst_n low in WAIT -> all outputs to reset values asynchronously; post-reset req0 granted first.
